// File: rtl/keypad_digit_entry_pkg.sv
// Shared definitions for the keypad digit-entry block: key codes, the
// key_data bit-to-code map and the debounce FSM state encoding.
// Optional feature macro used by this block: KEYPAD_AUTOREPEAT_EN.
package keypad_digit_entry_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_t;

    // Physical key order on key_data is 1..9, '*', 0, '#'.
    function automatic logic [3:0] bit_to_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd4;
            4'd4:    code = 4'd5;
            4'd5:    code = 4'd6;
            4'd6:    code = 4'd7;
            4'd7:    code = 4'd8;
            4'd8:    code = 4'd9;
            4'd9:    code = KEY_STAR;
            4'd10:   code = 4'd0;
            4'd11:   code = KEY_HASH;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    // Idle and multi-hot vectors both read as "no key".
    function automatic logic [3:0] decode_key(input logic [11:0] kd);
        logic [3:0] code;
        code = KEY_NONE;
        if ($onehot(kd)) begin
            for (int i = 0; i < 12; i++) begin
                if (kd[i]) code = bit_to_code(4'(i));
            end
        end
        return code;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_digit_entry_if.sv
// Keypad digit-entry signal bundle: scanner vector in, key events and the
// digit entry / commit registers out.
// Optional feature macro used by this block: KEYPAD_AUTOREPEAT_EN.
interface keypad_digit_entry_if;

    logic [11:0] key_data;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry_bcd;
    logic [2:0]  entry_len;
    logic        commit;
    logic [15:0] commit_bcd;
    logic        overflow;

    modport master (
        output key_data,
        input  key_valid, key_code, entry_bcd, entry_len, commit, commit_bcd, overflow
    );

    modport slave (
        input  key_data,
        output key_valid, key_code, entry_bcd, entry_len, commit, commit_bcd, overflow
    );

endinterface

// File: rtl/keypad_digit_entry_debounce.sv
// Key decode plus debounce FSM. One key event per accepted press; with
// KEYPAD_AUTOREPEAT_EN defined a held digit also re-fires periodically.
// DEBOUNCE_CYCLES must be at least 2.
//
//  state           | meaning
//  ----------------+-------------------------------------------------------
//  ST_IDLE         | no key accepted; waiting for a valid one-hot sample
//  ST_PRESS_WAIT   | counting identical samples of cand toward acceptance
//  ST_HELD         | press accepted; waiting for the key to change
//  ST_RELEASE_WAIT | counting NONE samples toward a debounced release
module keypad_digit_entry_debounce
    import keypad_digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_data,
    output logic        key_event,
    output logic [3:0]  key_event_code,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt, rpt_n;
`endif

    deb_state_t    state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    sample;
    logic          fire;

    assign sample         = decode_key(key_data);
    assign key_event      = fire;
    assign key_event_code = cand_n;

    // State, candidate, counters and the registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt       <= '0;
`endif
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_valid <= fire;
            if (fire) key_code <= cand_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt       <= rpt_n;
`endif
        end
    end

    // Next-state, counter updates and the event strobe.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        fire    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_n   = rpt;
`endif
        case (state)
            ST_IDLE: begin
                if (sample != KEY_NONE) begin
                    cand_n  = sample;
                    cnt_n   = CW'(1);
                    state_n = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (sample == KEY_NONE) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (sample != cand) begin
                    cand_n = sample;
                    cnt_n  = CW'(1);
                end else if (cnt == CNT_TC - CW'(1)) begin
                    fire    = 1'b1;
                    state_n = ST_HELD;
                    cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_n   = RPT_DLY;
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_HELD: begin
                if (sample != cand) begin
                    state_n = ST_RELEASE_WAIT;
                    cnt_n   = CW'(1);
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (is_digit(cand)) begin
                    if (rpt == '0) begin
                        fire  = 1'b1;
                        rpt_n = RPT_PER;
                    end else begin
                        rpt_n = rpt - RPT_W'(1);
                    end
                end
`endif
            end
            ST_RELEASE_WAIT: begin
                // A key reappearing (same or another) means no release yet.
                if (sample != KEY_NONE) begin
                    state_n = ST_HELD;
                    cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_n   = RPT_DLY;
`endif
                end else if (cnt == CNT_TC - CW'(1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad digit entry top: debounced key events drive a 4-digit BCD entry
// register with '*' = clear and '#' = commit.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (held digits auto-repeat).
module keypad_digit_entry
    import keypad_digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_digit_entry_if.slave   kp
);

    logic        key_event;
    logic [3:0]  key_event_code;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry_bcd;
    logic [2:0]  entry_len;
    logic        commit;
    logic [15:0] commit_bcd;
    logic        overflow;

    keypad_digit_entry_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_debounce (
        .clk            (clk),
        .rst            (rst),
        .key_data       (kp.key_data),
        .key_event      (key_event),
        .key_event_code (key_event_code),
        .key_valid      (key_valid),
        .key_code       (key_code)
    );

    // Entry/commit registers update on the same edge the key event is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_bcd  <= '0;
            entry_len  <= '0;
            commit     <= 1'b0;
            commit_bcd <= '0;
            overflow   <= 1'b0;
        end else begin
            commit   <= 1'b0;
            overflow <= 1'b0;
            if (key_event) begin
                if (is_digit(key_event_code)) begin
                    if (entry_len < 3'd4) begin
                        entry_bcd <= {entry_bcd[11:0], key_event_code};
                        entry_len <= entry_len + 3'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (key_event_code == KEY_STAR) begin
                    entry_bcd <= '0;
                    entry_len <= '0;
                end else if (key_event_code == KEY_HASH && entry_len != 3'd0) begin
                    commit_bcd <= entry_bcd;
                    commit     <= 1'b1;
                    entry_bcd  <= '0;
                    entry_len  <= '0;
                end
            end
        end
    end

    assign kp.key_valid  = key_valid;
    assign kp.key_code   = key_code;
    assign kp.entry_bcd  = entry_bcd;
    assign kp.entry_len  = entry_len;
    assign kp.commit     = commit;
    assign kp.commit_bcd = commit_bcd;
    assign kp.overflow   = overflow;

endmodule
